c3lib_ckmux4_sel_seq: RTL and testbench

// - Control-side sequencer for the 4:1 clock mux. Owns the mux selects {s1,s0}
//   and the enable of the downstream clock gate.
// - A select change is taken through a req/rdy handshake, then run as:

---
 rtl/c3lib_ckmux4_sel_seq.sv | 133 +++++++++++++
 tb/tb_c3lib_ckmux4_sel_seq.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/c3lib_ckmux4_sel_seq.sv
// Select sequencer for the 4:1 clock mux.
// A select change is accepted over a vld/rdy handshake. The sequencer then
// closes the downstream clock gate, lets the old clock drain, moves the mux
// selects, waits for the mux to settle and reopens the gate. Because the
// selects only move while the gate is closed, the gated clock never glitches.
module c3lib_ckmux4_sel_seq #(
    parameter int         GATE_OFF_CYC = 4,
    parameter int         SETTLE_CYC   = 8,
    parameter logic [1:0] RST_SEL      = 2'd0,
    parameter int         CNT_W        = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sel_req_vld,
    input  logic [1:0] sel_req,
    output logic       sel_req_rdy,
    output logic       sel_done,
    output logic [1:0] cur_sel,
    output logic       s0,
    output logic       s1,
    output logic       ck_gate_en,
    input  logic       tst_override
);

    localparam logic [2:0] ST_INIT   = 3'd0;
    localparam logic [2:0] ST_IDLE   = 3'd1;
    localparam logic [2:0] ST_DRAIN  = 3'd2;
    localparam logic [2:0] ST_SWITCH = 3'd3;
    localparam logic [2:0] ST_SETTLE = 3'd4;

    // Down-counters are loaded with N-1 and leave their state when they hit 0.
    localparam logic [CNT_W-1:0] G_LOAD = CNT_W'(GATE_OFF_CYC - 1);
    localparam logic [CNT_W-1:0] S_LOAD = CNT_W'(SETTLE_CYC - 1);

    // Refuse to build with parameters the counter cannot represent.
    if (GATE_OFF_CYC < 1 || SETTLE_CYC < 1 || CNT_W < 1 || CNT_W > 31 ||
        GATE_OFF_CYC > (1 << CNT_W) || SETTLE_CYC > (1 << CNT_W)) begin : g_bad_param
        $error("c3lib_ckmux4_sel_seq: GATE_OFF_CYC/SETTLE_CYC must be >=1 and fit in CNT_W bits");
    end

    logic [2:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       sel_q;
    logic [1:0]       req_q;
    logic             gate_en_q;
    logic             acc;
    logic             same_sel;

    assign sel_req_rdy = (state == ST_IDLE) && !tst_override;
    assign acc         = sel_req_vld && sel_req_rdy;
    assign same_sel    = (sel_req == sel_q);
    assign cur_sel     = sel_q;
    assign s0          = sel_q[0];
    assign s1          = sel_q[1];
    assign ck_gate_en  = gate_en_q | tst_override;

    // Sequencer: state, counter, latched request, selects, gate enable, done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_INIT;
            cnt       <= '0;
            sel_q     <= RST_SEL;
            req_q     <= RST_SEL;
            gate_en_q <= 1'b0;
            sel_done  <= 1'b0;
        end else begin
            sel_done <= 1'b0;
            case (state)
                // Power-up settle: gate stays closed for SETTLE_CYC cycles.
                ST_INIT: begin
                    if (cnt == S_LOAD) begin
                        state     <= ST_IDLE;
                        cnt       <= '0;
                        gate_en_q <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (acc) begin
                        if (same_sel) begin
                            sel_done <= 1'b1;
                        end else begin
                            req_q     <= sel_req;
                            gate_en_q <= 1'b0;
                            cnt       <= G_LOAD;
                            state     <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (cnt == '0) begin
                        sel_q <= req_q;
                        cnt   <= S_LOAD;
                        state <= ST_SWITCH;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                // SWITCH is the first settle cycle; both share the countdown.
                ST_SWITCH, ST_SETTLE: begin
                    if (cnt == '0) begin
                        gate_en_q <= 1'b1;
                        sel_done  <= 1'b1;
                        state     <= ST_IDLE;
                    end else begin
                        cnt   <= cnt - 1'b1;
                        state <= ST_SETTLE;
                    end
                end
                default: begin
                    state     <= ST_INIT;
                    cnt       <= '0;
                    gate_en_q <= 1'b0;
                end
            endcase
        end
    end

    // Selects never move while the gate is open.
    a_sel_stable: assert property (@(posedge clk) disable iff (rst)
        gate_en_q |-> $stable(sel_q));

    // Done is a pulse, except when a same-select request is accepted on the
    // done cycle itself (back-to-back completion).
    a_done_pulse: assert property (@(posedge clk) disable iff (rst)
        (sel_done && !(acc && same_sel)) |=> !sel_done);

    // Requests are only taken in IDLE.
    a_rdy_idle: assert property (@(posedge clk) disable iff (rst)
        (state != ST_IDLE) |-> !sel_req_rdy);

endmodule

// File: tb/tb_c3lib_ckmux4_sel_seq.sv
// Directed bench for the clock-mux select sequencer: one instance with the
// default timing and RST_SEL=2, one with G=1/S=1 for back-to-back requests.
module tb_c3lib_ckmux4_sel_seq;

    logic       clk = 1'b0;
    logic       rst, vld, ovr, rdy, done, s0, s1, gate;
    logic [1:0] req, cur;
    logic       frst, fvld, frdy, fdone, fs0, fs1, fgate;
    logic [1:0] freq, fcur;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    c3lib_ckmux4_sel_seq #(.GATE_OFF_CYC(4), .SETTLE_CYC(8), .RST_SEL(2'd2), .CNT_W(8)) u_dut (
        .clk(clk), .rst(rst), .sel_req_vld(vld), .sel_req(req), .sel_req_rdy(rdy),
        .sel_done(done), .cur_sel(cur), .s0(s0), .s1(s1), .ck_gate_en(gate),
        .tst_override(ovr));

    c3lib_ckmux4_sel_seq #(.GATE_OFF_CYC(1), .SETTLE_CYC(1), .RST_SEL(2'd0), .CNT_W(4)) u_dut_fast (
        .clk(clk), .rst(frst), .sel_req_vld(fvld), .sel_req(freq), .sel_req_rdy(frdy),
        .sel_done(fdone), .cur_sel(fcur), .s0(fs0), .s1(fs1), .ck_gate_en(fgate),
        .tst_override(1'b0));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Starts one cycle after the reset edge: 8 closed cycles, then IDLE.
    task automatic init_chk(input string tag);
        for (int n = 1; n <= 8; n++) begin
            chk({tag, "_gate0"}, 32'(gate), 0);
            chk({tag, "_rdy0"}, 32'(rdy), 0);
            chk({tag, "_done0"}, 32'(done), 0);
            chk({tag, "_sel"}, 32'({s1, s0}), 2);
            tick();
        end
        chk({tag, "_gate1"}, 32'(gate), 1);
        chk({tag, "_rdy1"}, 32'(rdy), 1);
        chk({tag, "_done_end"}, 32'(done), 0);
        chk({tag, "_sel_end"}, 32'({s1, s0}), 2);
    endtask

    // Called right after the accept edge; returns cycles to sel_done.
    task automatic wait_done(input int limit, output int lat);
        lat = 1;
        while (!done && lat < limit) begin
            tick();
            lat++;
        end
    endtask

    task automatic req_wait(input logic [1:0] v, input string tag);
        int lat;
        vld = 1'b1;
        req = v;
        tick();
        vld = 1'b0;
        wait_done(40, lat);
        chk({tag, "_lat"}, lat, 13);
        chk({tag, "_sel"}, 32'(cur), 32'(v));
    endtask

    initial begin
        int         lat;
        int         exp_lat;
        logic       flag;
        logic [1:0] v, model;

        rst = 1'b1; vld = 1'b0; req = 2'd0; ovr = 1'b0;
        frst = 1'b1; fvld = 1'b0; freq = 2'd0;
        repeat (3) tick();
        rst = 1'b0;
        init_chk("reset");

        // 2 -> 0, then the detailed 0 -> 3 timeline.
        req_wait(2'd0, "to0");
        vld = 1'b1; req = 2'd3;
        tick();
        vld = 1'b0;
        for (int n = 1; n <= 13; n++) begin
            chk("sw03_gate", 32'(gate), 32'(n == 13));
            chk("sw03_done", 32'(done), 32'(n == 13));
            chk("sw03_sel", 32'({s1, s0}), (n >= 5) ? 3 : 0);
            if (n < 13) tick();
        end

        // Same-select request completes next cycle with no gating.
        req_wait(2'd1, "to1");
        vld = 1'b1; req = 2'd1;
        tick();
        vld = 1'b0;
        chk("same_done", 32'(done), 1);
        chk("same_gate", 32'(gate), 1);
        chk("same_sel", 32'({s1, s0}), 1);
        tick();
        chk("same_done_off", 32'(done), 0);
        chk("same_gate2", 32'(gate), 1);

        // Reset in the middle of a 0 -> 2 switch.
        req_wait(2'd0, "to0b");
        vld = 1'b1; req = 2'd2;
        tick();
        vld = 1'b0;
        repeat (5) tick();
        chk("mid_gate0", 32'(gate), 0);
        chk("mid_sel", 32'({s1, s0}), 2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        init_chk("midrst");

        // Override blocks accepts and forces the gate open.
        ovr = 1'b1; vld = 1'b1; req = 2'd3;
        #1;
        chk("ovr_rdy0", 32'(rdy), 0);
        chk("ovr_gate", 32'(gate), 1);
        tick();
        chk("ovr_noacc_sel", 32'({s1, s0}), 2);
        chk("ovr_noacc_done", 32'(done), 0);
        chk("ovr_noacc_rdy", 32'(rdy), 0);
        ovr = 1'b0;
        #1;
        chk("ovr_rel_rdy", 32'(rdy), 1);
        tick();
        vld = 1'b0;
        chk("ovr_rel_gate0", 32'(gate), 0);
        wait_done(40, lat);
        chk("ovr_rel_lat", lat, 13);
        chk("ovr_rel_sel", 32'(cur), 3);

        // Override raised mid-sequence: completes, gate held open.
        vld = 1'b1; req = 2'd0;
        tick();
        vld = 1'b0;
        tick();
        ovr = 1'b1;
        #1;
        flag = 1'b0;
        lat = 2;
        while (!done && lat < 40) begin
            if (!gate) flag = 1'b1;
            tick();
            lat++;
        end
        chk("ovrmid_done", 32'(done), 1);
        chk("ovrmid_lat", lat, 13);
        chk("ovrmid_gate_drop", 32'(flag), 0);
        chk("ovrmid_sel", 32'(cur), 0);
        ovr = 1'b0;

        // Fast instance: back-to-back random requests, scoreboarded.
        repeat (2) tick();
        frst = 1'b0;
        lat = 0;
        while (!frdy && lat < 20) begin
            tick();
            lat++;
        end
        chk("fast_init_rdy", 32'(frdy), 1);
        model = 2'd0;
        for (int i = 0; i < 24; i++) begin
            v = 2'($urandom_range(0, 3));
            chk("fast_rdy", 32'(frdy), 1);
            fvld = 1'b1; freq = v;
            tick();
            fvld = 1'b0;
            exp_lat = (v == model) ? 1 : 3;
            model = v;
            lat = 1;
            while (!fdone && lat < 10) begin
                tick();
                lat++;
            end
            chk("fast_lat", lat, 32'(exp_lat));
            chk("fast_sel", 32'(fcur), 32'(model));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
